// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: request, retire and bypass signals of the register-file write-back queue
interface regfile_write_queue_if #(
    parameter int DEPTH = 4
);
    logic                     alu_wen;
    logic [4:0]               alu_wsel;
    logic [31:0]              alu_wdat;
    logic                     ld_wen;
    logic [4:0]               ld_wsel;
    logic [31:0]              ld_wdat;
    logic                     ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     wen;
    logic [4:0]               wsel;
    logic [31:0]              wdat;
    logic [4:0]               rsel1;
    logic [4:0]               rsel2;
    logic                     byp_hit1;
    logic                     byp_hit2;
    logic [31:0]              byp_dat1;
    logic [31:0]              byp_dat2;

    modport master (
        output alu_wen, alu_wsel, alu_wdat, ld_wen, ld_wsel, ld_wdat, rsel1, rsel2,
        input  ready, count, overflow, wen, wsel, wdat, byp_hit1, byp_hit2, byp_dat1, byp_dat2
    );

    modport slave (
        input  alu_wen, alu_wsel, alu_wdat, ld_wen, ld_wsel, ld_wdat, rsel1, rsel2,
        output ready, count, overflow, wen, wsel, wdat, byp_hit1, byp_hit2, byp_dat1, byp_dat2
    );
endinterface

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: two-in/one-out write-back queue in front of the register file, with operand bypass
module regfile_write_queue #(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    regfile_write_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    sel_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, ld_slot;
    logic [CW-1:0] count_q, count_d, push_n;
    logic          ovf_q, ovf_d;
    logic          ready, pop, alu_acc, ld_acc;
    logic          hit1, hit2;
    logic [31:0]   bd1, bd2;

    assign alu_acc = bus.alu_wen && bus.alu_wsel != 5'd0;
    assign ld_acc  = bus.ld_wen && bus.ld_wsel != 5'd0;
    assign ready   = count_q <= CW'(DEPTH - 2);
    assign pop     = count_q != '0;
    assign ld_slot = alu_acc ? tail_q + AW'(1) : tail_q;

    // Next state: pushes only when two free slots existed at cycle start, one retirement per non-empty cycle
    always_comb begin
        push_n  = ready ? CW'(alu_acc) + CW'(ld_acc) : '0;
        count_d = count_q + push_n - CW'(pop);
        tail_d  = tail_q + push_n[AW-1:0];
        head_d  = head_q + AW'(pop);
        ovf_d   = ovf_q || (!ready && (alu_acc || ld_acc));
    end

    // Pointer, count and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage: ALU request takes the tail slot first, the load request the slot after it
    always_ff @(posedge clk) begin
        if (ready && alu_acc) begin
            sel_q[tail_q] <= bus.alu_wsel;
            dat_q[tail_q] <= bus.alu_wdat;
        end
        if (ready && ld_acc) begin
            sel_q[ld_slot] <= bus.ld_wsel;
            dat_q[ld_slot] <= bus.ld_wdat;
        end
    end

    // Bypass search in age order from head so the youngest matching entry is the last one kept
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        bd1  = '0;
        bd2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && bus.rsel1 != 5'd0 && sel_q[head_q + AW'(i)] == bus.rsel1) begin
                hit1 = 1'b1;
                bd1  = dat_q[head_q + AW'(i)];
            end
            if (CW'(i) < count_q && bus.rsel2 != 5'd0 && sel_q[head_q + AW'(i)] == bus.rsel2) begin
                hit2 = 1'b1;
                bd2  = dat_q[head_q + AW'(i)];
            end
        end
    end

    assign bus.ready    = ready;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.wen      = pop;
    assign bus.wsel     = pop ? sel_q[head_q] : 5'd0;
    assign bus.wdat     = pop ? dat_q[head_q] : 32'd0;
    assign bus.byp_hit1 = hit1;
    assign bus.byp_hit2 = hit2;
    assign bus.byp_dat1 = bd1;
    assign bus.byp_dat2 = bd2;
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: vector table, corner sequences and random traffic against a queue model
module tb_regfile_write_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] dat;
    } ent_t;

    typedef struct {
        logic        aw;
        logic [4:0]  as;
        logic [31:0] ad;
        logic        lw;
        logic [4:0]  ls;
        logic [31:0] ld;
        logic [4:0]  r1;
        logic [31:0] e_cnt;
        logic        e_wen;
        logic [4:0]  e_sel;
        logic [31:0] e_dat;
        logic        e_hit;
        logic [31:0] e_bd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    ent_t q[$];
    logic m_ovf = 1'b0;
    vec_t tv[7];

    regfile_write_queue_if #(.DEPTH(DEPTH)) bus ();
    regfile_write_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic aw, input logic [4:0] as, input logic [31:0] ad,
                       input logic lw, input logic [4:0] ls, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
        bus.alu_wen = aw; bus.alu_wsel = as; bus.alu_wdat = ad;
        bus.ld_wen = lw; bus.ld_wsel = ls; bus.ld_wdat = ld;
        bus.rsel1 = r1; bus.rsel2 = r2;
    endtask

    function automatic logic [32:0] lookup(input logic [4:0] r);
        if (r != 5'd0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].sel == r) return {1'b1, q[i].dat};
        return 33'd0;
    endfunction

    // One cycle: check every output against the model, then advance the model across the edge
    task automatic cyc(input logic aw, input logic [4:0] as, input logic [31:0] ad,
                       input logic lw, input logic [4:0] ls, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
        logic        rdy;
        logic [32:0] b1, b2;
        drv(aw, as, ad, lw, ls, ld, r1, r2);
        #1;
        rdy = (DEPTH - q.size()) >= 2;
        b1 = lookup(r1);
        b2 = lookup(r2);
        chk("ready", 32'(bus.ready), 32'(rdy));
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("wen", 32'(bus.wen), 32'(q.size() != 0));
        chk("wsel", 32'(bus.wsel), q.size() != 0 ? 32'(q[0].sel) : 32'd0);
        chk("wdat", bus.wdat, q.size() != 0 ? q[0].dat : 32'd0);
        chk("byp_hit1", 32'(bus.byp_hit1), 32'(b1[32]));
        chk("byp_dat1", bus.byp_dat1, b1[31:0]);
        chk("byp_hit2", 32'(bus.byp_hit2), 32'(b2[32]));
        chk("byp_dat2", bus.byp_dat2, b2[31:0]);
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        if (rdy) begin
            if (aw && as != 5'd0) q.push_back({as, ad});
            if (lw && ls != 5'd0) q.push_back({ls, ld});
        end else if ((aw && as != 5'd0) || (lw && ls != 5'd0)) begin
            m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        int pushed;
        tv[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        tv[1] = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0};
        tv[2] = '{1, 3, 32'h11, 1, 3, 32'h22, 3, 2, 1, 3, 32'h11, 1, 32'h22};
        tv[3] = '{0, 0, 0, 0, 0, 0, 3, 1, 1, 3, 32'h22, 1, 32'h22};
        tv[4] = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};
        tv[5] = '{1, 0, 32'h55, 1, 0, 32'h66, 0, 0, 0, 0, 0, 0, 0};
        tv[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        do_reset();
        bus.rsel1 = 5'd5;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_wen", 32'(bus.wen), 32'd0);
        chk("rst_wsel", 32'(bus.wsel), 32'd0);
        chk("rst_wdat", bus.wdat, 32'd0);
        chk("rst_hit1", 32'(bus.byp_hit1), 32'd0);
        chk("rst_dat1", bus.byp_dat1, 32'd0);

        for (int i = 0; i < 7; i++) begin
            drv(tv[i].aw, tv[i].as, tv[i].ad, tv[i].lw, tv[i].ls, tv[i].ld, tv[i].r1, 5'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), 32'(bus.count), tv[i].e_cnt);
            chk($sformatf("v%0d_wen", i), 32'(bus.wen), 32'(tv[i].e_wen));
            chk($sformatf("v%0d_wsel", i), 32'(bus.wsel), 32'(tv[i].e_sel));
            chk($sformatf("v%0d_wdat", i), bus.wdat, tv[i].e_dat);
            chk($sformatf("v%0d_hit1", i), 32'(bus.byp_hit1), 32'(tv[i].e_hit));
            chk($sformatf("v%0d_dat1", i), bus.byp_dat1, tv[i].e_bd);
            chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'd0);
        end

        cyc(1, 1, 32'hA1, 1, 2, 32'hA2, 2, 1);
        cyc(1, 3, 32'hA3, 1, 4, 32'hA4, 3, 4);
        cyc(1, 5, 32'hA5, 1, 6, 32'hA6, 5, 6);
        chk("ovf_sticky_set", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd2);
        chk("ovf_head", 32'(bus.wsel), 32'd3);
        chk("ovf_head_dat", bus.wdat, 32'hA3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 4, 5);
        chk("ovf_sticky_hold", 32'(bus.overflow), 32'd1);

        do_reset();
        cyc(1, 7, 32'h70, 1, 8, 32'h80, 0, 0);
        cyc(1, 9, 32'h90, 1, 10, 32'hA0, 9, 10);
        drv(0, 0, 0, 0, 0, 0, 9, 10);
        #1;
        chk("pre_arst_count", 32'(bus.count), 32'd3);
        chk("pre_arst_hit1", 32'(bus.byp_hit1), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_wen", 32'(bus.wen), 32'd0);
        chk("arst_hit1", 32'(bus.byp_hit1), 32'd0);
        chk("arst_hit2", 32'(bus.byp_hit2), 32'd0);
        chk("arst_ready", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        cyc(1, 12, 32'h12345678, 0, 0, 0, 12, 0);
        chk("post_rst_wen", 32'(bus.wen), 32'd1);
        chk("post_rst_wsel", 32'(bus.wsel), 32'd12);
        chk("post_rst_wdat", bus.wdat, 32'h12345678);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        pushed = 0;
        for (int i = 0; i < 20; i++) begin
            logic [4:0] s1, s2;
            s1 = 5'($urandom_range(1, 31));
            s2 = 5'($urandom_range(1, 31));
            if ((DEPTH - q.size()) >= 2) begin
                cyc(1, s1, $urandom, i % 2 == 0, s2, $urandom, s1, s2);
                pushed += (i % 2 == 0) ? 2 : 1;
            end else begin
                cyc(0, 0, 0, 0, 0, 0, s1, s2);
            end
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sustain_pushed_some", 32'(pushed > 10), 32'd1);
        chk("sustain_drained", 32'(bus.count), 32'd0);
        chk("sustain_no_ovf", 32'(bus.overflow), 32'd0);

        do_reset();
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
